// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt priority controller.
package irq_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;
endpackage

// File: rtl/priority_encoder.sv
// 8:3 priority encoder; the highest set bit of D wins. The output is don't-care for D == 0.
module priority_encoder
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] D,
  output logic [IDX_W-1:0] y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < N_REQ; i++)
      if (D[i]) y = IDX_W'(i);
  end
endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt request controller: pending/enable registers, priority select and valid/ack handshake.
// Define IRQ_EDGE_DETECT_EN for edge capture with sticky overrun flags; the default build is level mode.
module irq_priority_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en_wr,
  input  logic [N_REQ-1:0] en_in,
  input  logic             irq_ack,
  input  logic             ovr_clr,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] en,
  output logic [N_REQ-1:0] overrun
);
  irq_state_t       state, state_nxt;
  logic [IDX_W-1:0] id_nxt, enc_id;
  logic [N_REQ-1:0] set, clr, cand;
  logic             ack_hit;

  assign ack_hit = (state == PRESENT) && irq_ack;
  assign clr     = ack_hit ? (N_REQ'(1) << irq_id) : '0;
  assign cand    = pending & en;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_REQ-1:0] req_q;

  assign set = req & ~req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      overrun <= '0;
    end else begin
      req_q   <= req;
      // A fresh overrun survives a simultaneous clear.
      overrun <= (ovr_clr ? '0 : overrun) | (set & pending & ~clr);
    end
  end
`else
  logic unused_ovr_clr;

  assign set            = req;
  assign overrun        = '0;
  assign unused_ovr_clr = ovr_clr;
`endif

  priority_encoder u_enc (
    .D (cand),
    .y (enc_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      en      <= '0;
      state   <= IDLE;
      irq_id  <= '0;
    end else begin
      // Set wins over the ack clear so a new event on the served line is kept.
      pending <= (pending & ~clr) | set;
      if (en_wr) en <= en_in;
      state   <= state_nxt;
      irq_id  <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    unique case (state)
      IDLE:
        if (cand != '0) begin
          state_nxt = PRESENT;
          id_nxt    = enc_id;
        end
      PRESENT:
        if (irq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_valid = (state == PRESENT);
endmodule
